// File: rtl/serial_pkg.sv
// Shared serial-link types and line constants.
// Used by both the transmitter and the receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  localparam int   DATA_BITS   = 8;
  localparam logic START_LEVEL = 1'b0;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef logic [DATA_BITS-1:0] byte_t;

  // Line level for a frame phase; only DATA carries payload.
  function automatic logic line_level(
    input state_t s,
    input logic   lsb
  );
    logic lvl;
    lvl = IDLE_LEVEL;
    unique case (s)
      IDLE:  lvl = IDLE_LEVEL;
      START: lvl = START_LEVEL;
      DATA:  lvl = lsb;
      STOP:  lvl = IDLE_LEVEL;
      default: lvl = IDLE_LEVEL;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous show-ahead FIFO with count-based full/empty.
// DEPTH must be a power of two so the pointers wrap for free.
module serial_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd;
  logic [AW-1:0]    wr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr] <= data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        wr <= wr + 1'b1;
      end
      if (do_pop) begin
        rd <= rd + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Byte-to-serial transmitter: start bit, 8 data bits LSB first, stop bits.
// Define SERIAL_TX_FIFO_EN to put an input FIFO ahead of the framer.
module serial_tx #(
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       busy
);

  import serial_pkg::*;

  if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_bad_stop
    $error("serial_tx: STOP_BITS out of range");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_tx: FIFO_DEPTH must be a power of two >= 2");
  end

  localparam logic [1:0] STOP_LAST = 2'(STOP_BITS - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [1:0] stop_cnt;
  byte_t      shift;

  logic  slot;
  logic  avail;
  logic  take;
  byte_t next_byte;

  // The framer can load a new byte when idle or in its final stop cycle.
  assign slot = (state == IDLE) ||
                (state == STOP && stop_cnt == STOP_LAST);
  assign take = slot && avail && !reset;

`ifdef SERIAL_TX_FIFO_EN
  logic  full;
  logic  empty;
  byte_t head;

  serial_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .data  (in_data),
    .pop   (take),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready  = !reset && !full;
  assign avail     = !empty;
  assign next_byte = head;
  assign busy      = (state != IDLE) || !empty;
`else
  assign in_ready  = !reset && slot;
  assign avail     = in_valid;
  assign next_byte = in_data;
  assign busy      = (state != IDLE);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            shift <= next_byte;
            state <= START;
          end
        end
        START: begin
          bit_cnt <= '0;
          state   <= DATA;
        end
        DATA: begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            stop_cnt <= '0;
            state    <= STOP;
          end
        end
        STOP: begin
          if (stop_cnt == STOP_LAST) begin
            stop_cnt <= '0;
            if (take) begin
              shift <= next_byte;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            stop_cnt <= stop_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tx = line_level(state, shift[0]);

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboarded bench for serial_tx: timeline model of frames and FIFO
// occupancy on the driver side, line decoder as the monitor.
module tb_serial_tx;

  parameter int SB = 1;
  localparam int DEPTH = 4;
  localparam int P = 9 + SB;
`ifdef SERIAL_TX_FIFO_EN
  localparam int LAT = 1;
  localparam bit FIFO = 1'b1;
`else
  localparam int LAT = 0;
  localparam bit FIFO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       tx;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    int         s;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   last_s = -1000;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;

  serial_tx #(
    .STOP_BITS  (SB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // One clock of stimulus. Cycle c is the interval after edge c; a byte
  // offered in cycle c is taken at edge c+1.
  task automatic step(input bit v, input logic [7:0] d, input bit r,
                      output bit hs);
    int cnt;
    bit in_frame;
    bit blocked;
    bit er;
    bit eb;
    int s;
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    reset    = r;
    #1;
    while (starts.size() > 0 && starts[0] + P - 1 < cyc)
      void'(starts.pop_front());
    cnt = 0;
    in_frame = 0;
    blocked = 0;
    foreach (starts[i]) begin
      if (starts[i] > cyc) cnt++;
      if (starts[i] <= cyc && cyc <= starts[i] + P - 1) in_frame = 1;
      if (starts[i] <= cyc && cyc <= starts[i] + P - 2) blocked = 1;
    end
    if (FIFO) begin
      er = !r && (cnt < DEPTH);
      eb = in_frame || (cnt > 0);
    end else begin
      er = !r && !blocked;
      eb = in_frame;
    end
    chk("in_ready", 32'(in_ready), 32'(er));
    chk("busy", 32'(busy), 32'(eb));
    hs = v && in_ready && !r;
    if (hs) begin
      s = cyc + 1 + LAT;
      if (s < last_s + P) s = last_s + P;
      last_s = s;
      starts.push_back(s);
      exp_q.push_back('{d: d, s: s});
    end
    if (r) begin
      starts.delete();
      last_s = -1000;
    end
  endtask

  task automatic send(input logic [7:0] d);
    bit hs;
    int n;
    n = 0;
    hs = 0;
    while (!hs && n < 60) begin
      step(1'b1, d, 1'b0, hs);
      n++;
    end
    if (!hs) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: byte %0h never accepted", d);
    end
  endtask

  task automatic idle(input int n);
    bit hs;
    repeat (n) step(1'b0, 8'($urandom), 1'b0, hs);
  endtask

  int         mstate = 0;
  int         bitn = 0;
  int         sn = 0;
  bit         ghost = 0;
  bit         stop_ok = 0;
  bit         post_rst = 0;
  logic [7:0] got = 8'h00;
  exp_t       cur;

  always @(negedge clk) begin
    if (post_rst) begin
      chk("tx_after_reset", 32'(tx), 32'd1);
      post_rst = 0;
    end
    if (reset) begin
      exp_q.delete();
      mstate = 0;
      post_rst = 1;
    end else begin
      case (mstate)
        0: begin
          if (tx == 1'b0) begin
            if (exp_q.size() == 0) begin
              vectors++;
              errors++;
              $display("FAIL spurious_frame: start bit at cycle %0d, none expected",
                       cyc);
              ghost = 1;
            end else begin
              cur = exp_q.pop_front();
              chk("start_time", cyc, cur.s);
              ghost = 0;
            end
            bitn = 0;
            got = 8'h00;
            mstate = 1;
          end
        end
        1: begin
          got[bitn[2:0]] = tx;
          bitn++;
          if (bitn == 8) begin
            sn = 0;
            stop_ok = 1;
            mstate = 2;
          end
        end
        default: begin
          if (tx !== 1'b1) stop_ok = 0;
          sn++;
          if (sn == SB) begin
            if (!ghost) begin
              chk("frame_byte", 32'(got), 32'(cur.d));
              chk("stop_bits", 32'(stop_ok), 32'd1);
            end
            mstate = 0;
          end
        end
      endcase
    end
  end

  initial begin
    bit hs;
    repeat (3) step(1'b0, 8'h00, 1'b1, hs);
    chk("reset_tx", 32'(tx), 32'd1);

    send(8'hA5);
    idle(P + 6);

    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    idle(4 * P);

    send(8'h81);
    send(8'h7E);
    idle(3 * P);

    send(8'h55);
    idle(4);
    step(1'b0, 8'h00, 1'b1, hs);
    step(1'b0, 8'h00, 1'b0, hs);
    chk("post_reset_tx", 32'(tx), 32'd1);
    idle(P + 5);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 1'b0, hs);
    idle(8 * P);

    for (int i = 0; i < 8; i++)
      send(8'($urandom));
    idle(10 * P);

    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d frames never left the line", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
